// File: rtl/axi_write_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | axi_write_master: writes one cache line as a single AW + INCR W burst + B.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module axi_write_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int AW_LEN     = 3,
  parameter int AW_SIZE    = 2,
  parameter int AW_BURST   = 1,
  parameter int LINE_WIDTH = 128
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [LINE_WIDTH-1:0]   req_data,
  input  logic [LINE_WIDTH/8-1:0] req_strb,
  output logic                    resp_valid,
  output logic                    resp_err,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    wvalid,
  input  logic                    wready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  input  logic                    bvalid,
  output logic                    bready,
  input  logic [1:0]              bresp
);

  localparam int CNT_W = (AW_LEN > 0) ? $clog2(AW_LEN + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(AW_LEN);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    AW_CHANNEL = 2'd1,
    W_CHANNEL  = 2'd2,
    B_CHANNEL  = 2'd3
  } state_t;

  state_t                                 state;
  logic [CNT_W-1:0]                       cnt;
  logic [ADDR_WIDTH-1:0]                  addr_q;
  logic [AW_LEN:0][DATA_WIDTH-1:0]        data_q;
  logic [AW_LEN:0][DATA_WIDTH/8-1:0]      strb_q;

  assign awaddr  = addr_q;
  assign awlen   = 8'(AW_LEN);
  assign awsize  = 3'(AW_SIZE);
  assign awburst = 2'(AW_BURST);
  // Beat select comes straight from registers, so W outputs hold while wready is low.
  assign wdata   = data_q[cnt];
  assign wstrb   = strb_q[cnt];
  assign wlast   = wvalid && (cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      strb_q     <= '0;
      req_ready  <= 1'b1;
      awvalid    <= 1'b0;
      wvalid     <= 1'b0;
      bready     <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            addr_q    <= req_addr;
            data_q    <= req_data;
            strb_q    <= req_strb;
            req_ready <= 1'b0;
            awvalid   <= 1'b1;
            state     <= AW_CHANNEL;
          end
        end
        AW_CHANNEL: begin
          if (awready) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b1;
            state   <= W_CHANNEL;
          end
        end
        W_CHANNEL: begin
          if (wready) begin
            if (cnt == LAST_CNT) begin
              cnt    <= '0;
              wvalid <= 1'b0;
              bready <= 1'b1;
              state  <= B_CHANNEL;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        B_CHANNEL: begin
          if (bvalid) begin
            bready     <= 1'b0;
            resp_valid <= 1'b1;
            // Only SLVERR/DECERR set bit 1; OKAY/EXOKAY complete cleanly.
            resp_err   <= bresp[1];
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_write_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_axi_write_master: vector table, corner sequences and random transfers.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_axi_write_master;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid, req_ready;
  logic [31:0]  req_addr;
  logic [127:0] req_data;
  logic [15:0]  req_strb;
  logic         resp_valid, resp_err;
  logic         awvalid, awready;
  logic [31:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         wvalid, wready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wlast;
  logic         bvalid, bready;
  logic [1:0]   bresp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_write_master dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_data(req_data), .req_strb(req_strb),
    .resp_valid(resp_valid), .resp_err(resp_err),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp)
  );

  typedef struct {
    logic [31:0]  addr;
    logic [127:0] data;
    logic [15:0]  strb;
    logic [1:0]   bresp;
    int           aw_stall;   // cycles awready stays low after the request
    logic [31:0]  wpat;       // wready value for the n-th cycle wvalid is seen
    int           b_stall;    // cycles bvalid waits after the last beat
    logic         exp_err;
    int           exp_lat;    // expected resp_valid cycle, -1 = unchecked
    logic         junk;       // drive a stray request at 0x2000 during W
    int           rst_beat;   // pulse reset while this beat is presented, -1 = never
  } vec_t;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cycle-level model of an AXI slave plus the expected line transfer.
  // Called at a negedge with the DUT idle; returns at the negedge of the
  // resp_valid cycle so a following call exercises back-to-back accept.
  task automatic do_txn(input vec_t v);
    int cyc = 0, nb = 0, widx = 0, bw = 0;
    bit aws = 0, bhs = 0, done = 0;
    logic bv;
    chk("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_addr = v.addr; req_data = v.data; req_strb = v.strb;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = v.bresp;
    @(negedge clk);
    req_valid = 1'b0; req_addr = ~v.addr; req_data = ~v.data; req_strb = ~v.strb;
    cyc = 1;
    while (!done && cyc < 300) begin
      chk("awvalid", awvalid, !aws);
      if (awvalid) begin
        chk("awaddr", awaddr, v.addr);
        chk("awlen", awlen, 8'd3);
        chk("awsize", awsize, 3'd2);
        chk("awburst", awburst, 2'd1);
      end
      chk("wvalid", wvalid, aws && nb <= 3);
      if (wvalid) begin
        chk("wdata", wdata, v.data[nb*32 +: 32]);
        chk("wstrb", wstrb, v.strb[nb*4 +: 4]);
        chk("wlast", wlast, nb == 3);
      end
      chk("bready", bready, nb == 4 && !bhs);
      chk("resp_valid", resp_valid, bhs);
      chk("req_ready", req_ready, bhs);
      if (bhs) begin
        chk("resp_err", resp_err, v.exp_err);
        if (v.exp_lat >= 0) chk("latency", cyc, v.exp_lat);
        bvalid = 1'b0;
        done = 1;
      end else if (v.rst_beat >= 0 && wvalid && nb == v.rst_beat) begin
        rst_n = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_awvalid", awvalid, 1'b0);
        chk("rst_wvalid", wvalid, 1'b0);
        chk("rst_bready", bready, 1'b0);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_cnt", dut.cnt, 0);
        done = 1;
      end else begin
        awready = (cyc > v.aw_stall);
        wready = wvalid ? ((widx < 32) ? v.wpat[widx] : 1'b1) : 1'b1;
        bv = (nb == 4) && (bw >= v.b_stall);
        bvalid = bv;
        req_valid = v.junk && aws && nb <= 3;
        if (req_valid) req_addr = 32'h2000;
        if (awvalid && awready) aws = 1;
        if (bready && bv) bhs = 1;
        if (nb == 4) bw++;
        if (wvalid) begin
          if (wready) nb++;
          widx++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    req_valid = 1'b0;
    if (!done) begin
      chk("timeout", 1'b1, 1'b0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    end
  endtask

  vec_t vecs[8];
  vec_t rv;

  initial begin
    vecs[0] = '{32'h1000, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 16'hFFFF, 2'b00,
                0, 32'hFFFF_FFFF, 0, 1'b0, 7, 1'b0, -1};
    vecs[1] = '{32'h1040, 128'h44444444_33333333_22222222_11111111, 16'h0F3C, 2'b00,
                0, 32'hFFFF_FFD9, 0, 1'b0, -1, 1'b0, -1};
    vecs[2] = '{32'h3000, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 16'hA5A5, 2'b00,
                5, 32'hFFFF_FFFF, 0, 1'b0, -1, 1'b0, -1};
    vecs[3] = '{32'h4000, 128'hCAFEBABE_DEADBEEF_01010101_80808080, 16'hFFFF, 2'b10,
                1, 32'hFFFF_FFFF, 3, 1'b1, -1, 1'b0, -1};
    vecs[4] = '{32'h5000, 128'h55555555_66666666_77777777_88888888, 16'h1234, 2'b01,
                0, 32'hFFFF_FFFF, 0, 1'b0, -1, 1'b0, -1};
    vecs[5] = '{32'h1000, 128'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC, 16'hFFFF, 2'b00,
                0, 32'hFFFF_FFFF, 0, 1'b0, 7, 1'b1, -1};
    vecs[6] = '{32'h6000, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 16'hFFFF, 2'b00,
                0, 32'hFFFF_FFFF, 0, 1'b0, -1, 1'b0, 2};
    vecs[7] = '{32'h1000, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 16'hFFFF, 2'b11,
                0, 32'hFFFF_FFFF, 0, 1'b1, 7, 1'b0, -1};

    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_data = '0; req_strb = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    repeat (2) @(negedge clk);
    chk("reset_awvalid", awvalid, 1'b0);
    chk("reset_wvalid", wvalid, 1'b0);
    chk("reset_bready", bready, 1'b0);
    chk("reset_resp_valid", resp_valid, 1'b0);
    chk("reset_resp_err", resp_err, 1'b0);
    chk("reset_awaddr", awaddr, 32'h0);
    chk("reset_wlast", wlast, 1'b0);
    rst_n = 1'b1;

    // Directed table, applied back-to-back (each accept lands in the prior resp cycle).
    for (int i = 0; i < 8; i++) do_txn(vecs[i]);

    // Random transfers checked against the transaction-level expectations.
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        chk("idle_gap_resp_valid", resp_valid, 1'b0);
      end
      rv.addr     = $urandom & 32'hFFFF_FFF0;
      rv.data     = {$urandom, $urandom, $urandom, $urandom};
      rv.strb     = 16'($urandom);
      rv.bresp    = 2'($urandom_range(0, 3));
      rv.aw_stall = $urandom_range(0, 4);
      rv.wpat     = $urandom;
      rv.b_stall  = $urandom_range(0, 3);
      rv.exp_err  = (rv.bresp == 2'b10) || (rv.bresp == 2'b11);
      rv.exp_lat  = -1;
      rv.junk     = 1'($urandom_range(0, 1));
      rv.rst_beat = -1;
      do_txn(rv);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
